// File: rtl/ucode_pkg.sv
// Shared encodings, micro-word layout, opcode dispatch table and the built-in
// microcode image used when the ROM is not loaded from a hex file.
package ucode_pkg;

    localparam int OPC_W   = 8;
    localparam int UADDR_W = 8;
    localparam int CW_W    = 32;
    localparam int ROM_DEPTH = 2 ** UADDR_W;

    // Micro-word = {seq_op[1:0], cond_en, target[UADDR_W-1:0], ctrl[CW_W-1:0]}
    localparam int CTRL_LSB = 0;
    localparam int TGT_LSB  = CW_W;
    localparam int COND_BIT = CW_W + UADDR_W;
    localparam int SEQ_LSB  = COND_BIT + 1;
    localparam int SEQ_W    = 2;
    localparam int UW_W     = SEQ_LSB + SEQ_W;

    localparam int ERR_ILLEGAL  = 0;
    localparam int ERR_OVERFLOW = 1;

    typedef enum logic [1:0] {
        SEQ_NEXT = 2'd0,
        SEQ_JUMP = 2'd1,
        SEQ_END  = 2'd2,
        SEQ_HALT = 2'd3
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [UADDR_W-1:0] start;
    } dispatch_t;

    function automatic dispatch_t dispatch(input logic [OPC_W-1:0] opcode);
        dispatch_t d;
        d.valid = 1'b1;
        d.start = '0;
        case (opcode)
            8'h01:   d.start = 8'h10;
            8'h02:   d.start = 8'h20;
            8'h03:   d.start = 8'h50;
            8'h04:   d.start = 8'h60;
            8'h05:   d.start = 8'hFE;
            8'h06:   d.start = 8'h70;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [UW_W-1:0] pack_uword(input seq_op_t op, input logic cond,
                                                   input logic [UADDR_W-1:0] tgt,
                                                   input logic [CW_W-1:0] ctrl);
        return {op, cond, tgt, ctrl};
    endfunction

    // Every word's ctrl field carries a marker plus its own address, so the
    // datapath side can tell exactly which micro-op it received.
    function automatic logic [UW_W-1:0] default_uword(input logic [UADDR_W-1:0] addr);
        logic [CW_W-1:0] ctrl;
        ctrl = {24'hA50000, addr};
        case (addr)
            8'h10, 8'h11, 8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'hFE, 8'hFF:
                return pack_uword(SEQ_NEXT, 1'b0, '0, ctrl);
            8'h20:   return pack_uword(SEQ_JUMP, 1'b1, 8'h40, ctrl);
            8'h70:   return pack_uword(SEQ_JUMP, 1'b0, 8'h70, ctrl);
            8'h61:   return pack_uword(SEQ_HALT, 1'b0, '0, ctrl);
            default: return pack_uword(SEQ_END, 1'b0, '0, ctrl);
        endcase
    endfunction

endpackage

// File: rtl/ucode_rom.sv
// Synchronous-read microcode store; contents come from the built-in image in
// the package, either preloaded into a memory array or decoded per address.
module ucode_rom
  import ucode_pkg::*;
#(
  parameter int    AW        = UADDR_W,
  parameter int    W         = UW_W,
  parameter int    DEPTH     = 2 ** AW,
  parameter bit    FROM_FILE = 1'b1,
  parameter string INIT_FILE = "ucode.hex"
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  output logic [W-1:0]  o_q
);

  generate
    if (FROM_FILE) begin : g_file
      logic [W-1:0] r_mem [DEPTH];

      initial begin
        for (int a = 0; a < DEPTH; a++) begin
          r_mem[a] = W'(default_uword(UADDR_W'(a)));
        end
      end

      always_ff @(posedge i_clk) begin
        o_q <= r_mem[i_addr];
      end
    end else begin : g_const
      always_ff @(posedge i_clk) begin
        o_q <= W'(default_uword(UADDR_W'(i_addr)));
      end
    end
  endgenerate

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: accepts decoded opcodes, steps a micro-PC through the
// ROM and emits one control word per enabled cycle to the datapath.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter bit    ROM_FROM_FILE = 1'b1,
    parameter string ROM_FILE      = "ucode.hex"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             inst_valid,
    input  logic [OPC_W-1:0] inst_opcode,
    output logic             inst_ready,
    input  logic             dp_flag,
    output logic             cw_valid,
    output logic [CW_W-1:0]  cw_out,
    output logic             busy,
    output logic             halt_f,
    output logic [1:0]       err_bits,
    output logic [1:0]       dbg_state
);

    state_t             r_state;
    logic [UADDR_W-1:0] r_upc;
    logic               r_halt;
    logic [1:0]         r_err;

    logic [UW_W-1:0]    w_rom_q;
    logic [UADDR_W-1:0] w_upc_d;
    logic [UADDR_W-1:0] w_upc_inc;
    logic [UADDR_W-1:0] w_target;
    seq_op_t            w_seq;
    logic               w_cond;
    logic               w_accept;
    logic               w_take;
    logic               w_step;
    logic               w_overflow;
    dispatch_t          w_disp;

    // Handshake: an opcode transfers on a posedge where inst_valid and
    // inst_ready are both 1; inst_ready depends only on state, clk_en and rst.
    assign inst_ready = rst & clk_en & (r_state == ST_IDLE);
    assign cw_valid   = rst & clk_en & (r_state == ST_EXEC);
    assign busy       = rst & (r_state == ST_EXEC);
    assign cw_out     = w_rom_q[CTRL_LSB +: CW_W];
    assign halt_f     = r_halt;
    assign err_bits   = r_err;
    assign dbg_state  = r_state;

    assign w_seq      = seq_op_t'(w_rom_q[SEQ_LSB +: SEQ_W]);
    assign w_cond     = w_rom_q[COND_BIT];
    assign w_target   = w_rom_q[TGT_LSB +: UADDR_W];
    assign w_accept   = inst_valid & inst_ready;
    assign w_disp     = dispatch(inst_opcode);
    assign w_upc_inc  = r_upc + UADDR_W'(1);

    assign w_take     = (w_seq == SEQ_JUMP) && (!w_cond || dp_flag);
    assign w_step     = (w_seq == SEQ_NEXT) || ((w_seq == SEQ_JUMP) && !w_take);
    // Sequential fall-through past the last ROM word is an error, never a wrap.
    assign w_overflow = w_step && (&r_upc);

    // The ROM is addressed by the next micro-PC so its output is always word[upc].
    always_comb begin
        w_upc_d = r_upc;
        if (!rst) begin
            w_upc_d = '0;
        end else if (clk_en) begin
            if (r_state == ST_IDLE && w_accept && w_disp.valid) begin
                w_upc_d = w_disp.start;
            end else if (r_state == ST_EXEC) begin
                if (w_take) begin
                    w_upc_d = w_target;
                end else if (w_step && !w_overflow) begin
                    w_upc_d = w_upc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_upc   <= '0;
            r_halt  <= 1'b0;
            r_err   <= 2'b00;
        end else if (clk_en) begin
            r_upc <= w_upc_d;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_disp.valid) begin
                            r_state <= ST_EXEC;
                        end else begin
                            r_err[ERR_ILLEGAL] <= 1'b1;
                            r_halt             <= 1'b1;
                            r_state            <= ST_ERROR;
                        end
                    end
                end
                ST_EXEC: begin
                    case (w_seq)
                        SEQ_NEXT, SEQ_JUMP: begin
                            if (w_overflow) begin
                                r_err[ERR_OVERFLOW] <= 1'b1;
                                r_halt              <= 1'b1;
                                r_state             <= ST_ERROR;
                            end
                        end
                        SEQ_END: r_state <= ST_IDLE;
                        SEQ_HALT: begin
                            r_halt  <= 1'b1;
                            r_state <= ST_HALTED;
                        end
                        default: r_state <= ST_EXEC;
                    endcase
                end
                default: r_state <= r_state;
            endcase
        end
    end

    ucode_rom #(
        .AW        (UADDR_W),
        .W         (UW_W),
        .DEPTH     (ROM_DEPTH),
        .FROM_FILE (ROM_FROM_FILE),
        .INIT_FILE (ROM_FILE)
    ) u_rom (
        .i_clk  (clk),
        .i_addr (w_upc_d),
        .o_q    (w_rom_q)
    );

endmodule
